// File: rtl/csr_access_unit_if.sv
// Request/response and CSR set/clear bus bundle for csr_access_unit.
// master is the access unit's view; slave is execute stage + CSR file side.
interface csr_access_unit_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [11:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        req_src_zero_i;
  logic [1:0]  priv_i;
  logic        flush_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_illegal_o;
  logic        csr_en_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_set_o;
  logic [31:0] csr_clear_o;
  logic        csr_ack_i;
  logic [31:0] csr_rdata_i;

  modport master (
    input  req_valid_i, req_op_i, req_addr_i, req_wdata_i, req_src_zero_i,
           priv_i, flush_i, rsp_ready_i, csr_ack_i, csr_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_illegal_o,
           csr_en_o, csr_addr_o, csr_set_o, csr_clear_o
  );

  modport slave (
    output req_valid_i, req_op_i, req_addr_i, req_wdata_i, req_src_zero_i,
           priv_i, flush_i, rsp_ready_i, csr_ack_i, csr_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_illegal_o,
           csr_en_o, csr_addr_o, csr_set_o, csr_clear_o
  );
endinterface

// File: rtl/csr_access_unit.sv
// CSR instruction initiator: probe (read + ack check), optional set/clear write,
// then old value or illegal flag on a valid/ready response port.
module csr_access_unit #(
  parameter bit RO_CHECK   = 1'b1,
  parameter bit PRIV_CHECK = 1'b1
) (
  input logic              clk_i,
  input logic              rst_i,
  csr_access_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, PROBE, WRITE, RESP} state_e;
  localparam logic [1:0] OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11;

  state_e      state;
  logic [1:0]  op_q, priv_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q, rdata_q;
  logic        src_zero_q;

  logic        wr, illegal;
  logic [31:0] set_nxt, clr_nxt;

  assign wr      = (op_q == OP_RW) || !src_zero_q;
  assign illegal = !bus.csr_ack_i
                || (PRIV_CHECK && (addr_q[9:8] > priv_q))
                || (RO_CHECK && wr && (addr_q[11:10] == 2'b11));

  always_comb begin
    set_nxt = '0;
    clr_nxt = '0;
    case (op_q)
      OP_RW: begin set_nxt = wdata_q; clr_nxt = ~wdata_q; end
      OP_RS: set_nxt = wdata_q;
      OP_RC: clr_nxt = wdata_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= IDLE;
      op_q              <= '0;
      priv_q            <= '0;
      addr_q            <= '0;
      wdata_q           <= '0;
      rdata_q           <= '0;
      src_zero_q        <= 1'b0;
      bus.req_ready_o   <= 1'b1;
      bus.rsp_valid_o   <= 1'b0;
      bus.rsp_rdata_o   <= '0;
      bus.rsp_illegal_o <= 1'b0;
      bus.csr_en_o      <= 1'b0;
      bus.csr_addr_o    <= '0;
      bus.csr_set_o     <= '0;
      bus.csr_clear_o   <= '0;
    end else begin
      // Bus outputs live for exactly one state; only PROBE/WRITE entry re-arms them.
      bus.csr_en_o    <= 1'b0;
      bus.csr_addr_o  <= '0;
      bus.csr_set_o   <= '0;
      bus.csr_clear_o <= '0;
      case (state)
        IDLE: if (bus.req_valid_i && !bus.flush_i) begin
          op_q            <= bus.req_op_i;
          addr_q          <= bus.req_addr_i;
          wdata_q         <= bus.req_wdata_i;
          src_zero_q      <= bus.req_src_zero_i;
          priv_q          <= bus.priv_i;
          bus.req_ready_o <= 1'b0;
          if (bus.req_op_i == 2'b00) begin
            state             <= RESP;
            bus.rsp_valid_o   <= 1'b1;
            bus.rsp_rdata_o   <= '0;
            bus.rsp_illegal_o <= 1'b1;
          end else begin
            state          <= PROBE;
            bus.csr_en_o   <= 1'b1;
            bus.csr_addr_o <= bus.req_addr_i;
          end
        end
        PROBE: begin
          if (bus.flush_i) begin
            state           <= IDLE;
            bus.req_ready_o <= 1'b1;
          end else if (illegal || !wr) begin
            state             <= RESP;
            bus.rsp_valid_o   <= 1'b1;
            bus.rsp_rdata_o   <= illegal ? 32'h0 : bus.csr_rdata_i;
            bus.rsp_illegal_o <= illegal;
          end else begin
            state           <= WRITE;
            rdata_q         <= bus.csr_rdata_i;
            bus.csr_en_o    <= 1'b1;
            bus.csr_addr_o  <= addr_q;
            bus.csr_set_o   <= set_nxt;
            bus.csr_clear_o <= clr_nxt;
          end
        end
        WRITE: begin
          // The write is already on the bus this cycle; a flush only drops the response.
          if (bus.flush_i) begin
            state           <= IDLE;
            bus.req_ready_o <= 1'b1;
          end else begin
            state             <= RESP;
            bus.rsp_valid_o   <= 1'b1;
            bus.rsp_rdata_o   <= rdata_q;
            bus.rsp_illegal_o <= 1'b0;
          end
        end
        RESP: if (bus.rsp_ready_i || bus.flush_i) begin
          state             <= IDLE;
          bus.req_ready_o   <= 1'b1;
          bus.rsp_valid_o   <= 1'b0;
          bus.rsp_rdata_o   <= '0;
          bus.rsp_illegal_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a two-register CSR file model
// (mcause at 0x342, read-only mhartid at 0xF14).
module tb_csr_access_unit;
  localparam logic [31:0] HARTID = 32'h0000_0005;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_access_unit_if bus();

  csr_access_unit #(.RO_CHECK(1'b1), .PRIV_CHECK(1'b1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [31:0] mcause = 32'h2;
  logic [31:0] last_set = '0, last_clear = '0;
  int en_cnt = 0;
  int n_chk = 0, n_fail = 0;

  assign bus.csr_ack_i   = bus.csr_en_o && (bus.csr_addr_o == 12'h342 || bus.csr_addr_o == 12'hF14);
  assign bus.csr_rdata_i = (bus.csr_addr_o == 12'h342) ? mcause :
                           (bus.csr_addr_o == 12'hF14) ? HARTID : 32'h0;

  // CSR file model: set wins over clear; mhartid ignores writes.
  always @(posedge clk) begin
    if (bus.csr_en_o) begin
      en_cnt = en_cnt + 1;
      if ((bus.csr_set_o | bus.csr_clear_o) != 32'h0) begin
        last_set   = bus.csr_set_o;
        last_clear = bus.csr_clear_o;
      end
      if (bus.csr_addr_o == 12'h342)
        mcause <= (mcause & ~bus.csr_clear_o) | bus.csr_set_o;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic sz, input logic [1:0] priv);
    bus.req_valid_i    = 1'b1;
    bus.req_op_i       = op;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wdata;
    bus.req_src_zero_i = sz;
    bus.priv_i         = priv;
    en_cnt             = 0;
    tick;
    bus.req_valid_i    = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.rsp_valid_o && lat < 20) begin
      tick;
      lat++;
    end
  endtask

  task automatic txn(input string tag, input logic [1:0] op, input logic [11:0] addr,
                     input logic [31:0] wdata, input logic sz, input logic [1:0] priv,
                     input int exp_lat, input logic [31:0] exp_rdata, input logic exp_ill,
                     input int exp_en);
    int lat;
    issue(op, addr, wdata, sz, priv);
    wait_rsp(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, bus.rsp_rdata_o, exp_rdata);
    chk({tag, "_illegal"}, 32'(bus.rsp_illegal_o), 32'(exp_ill));
    chk({tag, "_buscyc"}, 32'(en_cnt), 32'(exp_en));
    tick;
  endtask

  initial begin
    int lat;
    bus.req_valid_i = 1'b0; bus.req_op_i = '0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    bus.req_src_zero_i = 1'b0; bus.priv_i = 2'd3; bus.flush_i = 1'b0; bus.rsp_ready_i = 1'b1;
    tick; tick;
    chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_en", 32'(bus.csr_en_o), 32'd0);
    chk("rst_addr", 32'(bus.csr_addr_o), 32'd0);
    chk("rst_set", bus.csr_set_o, 32'd0);
    chk("rst_clear", bus.csr_clear_o, 32'd0);
    rst = 1'b0;
    tick;

    txn("rw_mcause", 2'b01, 12'h342, 32'h8000_000B, 1'b0, 2'd3, 3, 32'h2, 1'b0, 2);
    chk("rw_set", last_set, 32'h8000_000B);
    chk("rw_clear", last_clear, 32'h7FFF_FFF4);
    chk("rw_mcause_val", mcause, 32'h8000_000B);

    txn("rs_zero", 2'b10, 12'h342, 32'h0, 1'b1, 2'd3, 2, 32'h8000_000B, 1'b0, 1);
    chk("rs_zero_mcause", mcause, 32'h8000_000B);

    txn("unmapped", 2'b01, 12'h7C0, 32'h1234, 1'b0, 2'd3, 2, 32'h0, 1'b1, 1);
    txn("rw_ro", 2'b01, 12'hF14, 32'h1, 1'b0, 2'd3, 2, 32'h0, 1'b1, 1);
    txn("rs_ro_read", 2'b10, 12'hF14, 32'h0, 1'b1, 2'd3, 2, HARTID, 1'b0, 1);
    txn("rc_priv0", 2'b11, 12'h342, 32'h3, 1'b0, 2'd0, 2, 32'h0, 1'b1, 1);
    chk("rc_priv0_mcause", mcause, 32'h8000_000B);
    txn("rc_priv3", 2'b11, 12'h342, 32'h3, 1'b0, 2'd3, 3, 32'h8000_000B, 1'b0, 2);
    chk("rc_set", last_set, 32'h0);
    chk("rc_clear", last_clear, 32'h3);
    chk("rc_mcause", mcause, 32'h8000_0008);
    txn("op00", 2'b00, 12'h342, 32'hFFFF_FFFF, 1'b0, 2'd3, 1, 32'h0, 1'b1, 0);

    // Response back-pressure: valid and data held while ready is low.
    bus.rsp_ready_i = 1'b0;
    issue(2'b10, 12'h342, 32'h10, 1'b0, 2'd3);
    wait_rsp(lat);
    chk("hold_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("hold_rdata", bus.rsp_rdata_o, 32'h8000_0008);
      tick;
    end
    bus.rsp_ready_i = 1'b1;
    tick;
    chk("hold_done", 32'(bus.rsp_valid_o), 32'd0);
    chk("hold_mcause", mcause, 32'h8000_0018);

    // Flush while probing: no write, no response.
    issue(2'b01, 12'h342, 32'h0, 1'b0, 2'd3);
    bus.flush_i = 1'b1;
    tick;
    bus.flush_i = 1'b0;
    tick; tick;
    chk("flp_rsp", 32'(bus.rsp_valid_o), 32'd0);
    chk("flp_ready", 32'(bus.req_ready_o), 32'd1);
    chk("flp_buscyc", 32'(en_cnt), 32'd1);
    chk("flp_mcause", mcause, 32'h8000_0018);

    // Flush during the write cycle: write lands, response dropped.
    issue(2'b10, 12'h342, 32'h100, 1'b0, 2'd3);
    tick;
    bus.flush_i = 1'b1;
    tick;
    bus.flush_i = 1'b0;
    tick;
    chk("flw_rsp", 32'(bus.rsp_valid_o), 32'd0);
    chk("flw_ready", 32'(bus.req_ready_o), 32'd1);
    chk("flw_mcause", mcause, 32'h8000_0118);

    // Reset asserted in the middle of a write cycle.
    issue(2'b01, 12'h342, 32'h0000_AAAA, 1'b0, 2'd3);
    tick;
    chk("rstw_in_write", 32'(bus.csr_en_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw_en", 32'(bus.csr_en_o), 32'd0);
    chk("rstw_set", bus.csr_set_o, 32'd0);
    chk("rstw_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rstw_rsp", 32'(bus.rsp_valid_o), 32'd0);
    tick;
    rst = 1'b0;
    tick;
    chk("rstw_mcause", mcause, 32'h8000_0118);
    txn("post_rst", 2'b10, 12'h342, 32'h0, 1'b1, 2'd3, 2, 32'h8000_0118, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
